// File: rtl/pclk_div_pkg.sv
// rtl/pclk_div_pkg.sv - shared constants and ratio decoding for the pclk divider
package pclk_div_pkg;

    localparam int CNT_W   = 7;
    localparam int DIV_MAX = 128;

    // Maps a ratio string to its numeric divisor; 0 flags an unsupported value.
    function automatic int div_ratio(input string ratio);
        if (ratio == "X2")   return 2;
        if (ratio == "X4")   return 4;
        if (ratio == "X8")   return 8;
        if (ratio == "X16")  return 16;
        if (ratio == "X32")  return 32;
        if (ratio == "X64")  return 64;
        if (ratio == "X128") return DIV_MAX;
        return 0;
    endfunction

endpackage

// File: rtl/pclk_div_sp.sv
// rtl/pclk_div_sp.sv - power-of-two clock divider with restart, optional tick/valid (PCLKDIV_TICK_EN)
module pclk_div_sp
    import pclk_div_pkg::*;
#(
    parameter string DIV_PCLKDIV = "X16"
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_div_rst,
    output logic             o_clkout,
    output logic             o_tick,
    output logic             o_valid,
    output logic [CNT_W-1:0] o_phase
);

    localparam int               DIV_N    = div_ratio(DIV_PCLKDIV);
    localparam int               CLK_BIT  = (DIV_N > 1) ? $clog2(DIV_N) - 1 : 0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_N - 1);

    if (DIV_N == 0) begin : g_bad_ratio
        $error("pclk_div_sp: unsupported DIV_PCLKDIV value %s", DIV_PCLKDIV);
    end

    logic [CNT_W-1:0] cnt;
    logic             cnt_last;

    assign cnt_last = (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (i_div_rst) begin
            cnt <= '0;
        end else if (cnt_last) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 7'd1;
        end
    end

    // Output clock is a counter register bit, so it cannot glitch.
    assign o_clkout = cnt[CLK_BIT];
    assign o_phase  = cnt;

`ifdef PCLKDIV_TICK_EN
    logic tick_q;
    logic valid_q;

    always_ff @(posedge clk) begin
        if (!rst_n || i_div_rst) begin
            tick_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            tick_q  <= cnt_last;
            valid_q <= valid_q | cnt_last;
        end
    end

    assign o_tick  = tick_q;
    assign o_valid = valid_q;
`else
    logic out_en_q;

    // Without tick logic, valid only reflects that reset has been released.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_en_q <= 1'b0;
        end else begin
            out_en_q <= 1'b1;
        end
    end

    assign o_tick  = 1'b0;
    assign o_valid = out_en_q;
`endif

endmodule

// File: tb/tb_pclk_div_sp.sv
// tb/tb_pclk_div_sp.sv - directed self-checking bench for pclk_div_sp at X16, X2, X128 and X8
module tb_pclk_div_sp;

`ifdef PCLKDIV_TICK_EN
    localparam bit TICK_EN = 1'b1;
`else
    localparam bit TICK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic [3:0] rst_n;
    logic [3:0] drst;
    logic [3:0] clkout;
    logic [3:0] tick;
    logic [3:0] valid;
    logic [6:0] phase [4];

    int checks = 0;
    int errors = 0;
    int nv [4] = '{16, 2, 128, 8};

    always #5 clk = ~clk;

    pclk_div_sp #(.DIV_PCLKDIV("X16")) u_x16 (
        .clk(clk), .rst_n(rst_n[0]), .i_div_rst(drst[0]),
        .o_clkout(clkout[0]), .o_tick(tick[0]), .o_valid(valid[0]), .o_phase(phase[0]));
    pclk_div_sp #(.DIV_PCLKDIV("X2")) u_x2 (
        .clk(clk), .rst_n(rst_n[1]), .i_div_rst(drst[1]),
        .o_clkout(clkout[1]), .o_tick(tick[1]), .o_valid(valid[1]), .o_phase(phase[1]));
    pclk_div_sp #(.DIV_PCLKDIV("X128")) u_x128 (
        .clk(clk), .rst_n(rst_n[2]), .i_div_rst(drst[2]),
        .o_clkout(clkout[2]), .o_tick(tick[2]), .o_valid(valid[2]), .o_phase(phase[2]));
    pclk_div_sp #(.DIV_PCLKDIV("X8")) u_x8 (
        .clk(clk), .rst_n(rst_n[3]), .i_div_rst(drst[3]),
        .o_clkout(clkout[3]), .o_tick(tick[3]), .o_valid(valid[3]), .o_phase(phase[3]));

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut=%0d observed=%0h expected=%0h", tag, d, obs, exp);
        end
    endtask

    // k = edges since the last reset/restart edge; vexp = expected o_valid
    task automatic chk_dut(input int d, input int k, input logic vexp);
        int n;
        int m;
        n = nv[d];
        m = k % n;
        chk("phase",  d, 32'(phase[d]),  32'(m));
        chk("clkout", d, 32'(clkout[d]), 32'(m >= n / 2));
        chk("tick",   d, 32'(tick[d]),   32'(TICK_EN && k >= n && m == 0));
        chk("valid",  d, 32'(valid[d]),  32'(vexp));
    endtask

    task automatic chk_zero(input int d, input logic vexp);
        chk("rst_phase",  d, 32'(phase[d]),  32'd0);
        chk("rst_clkout", d, 32'(clkout[d]), 32'd0);
        chk("rst_tick",   d, 32'(tick[d]),   32'd0);
        chk("rst_valid",  d, 32'(valid[d]),  32'(vexp));
    endtask

    initial begin
        rst_n = 4'h0;
        drst  = 4'h0;
        step();
        step();
        for (int d = 0; d < 4; d++) chk_zero(d, 1'b0);
        rst_n = 4'hF;

        // Free run from a common reset: edge 8 rise, edge 16 fall/tick for X16, etc.
        for (int k = 1; k <= 140; k++) begin
            step();
            for (int d = 0; d < 4; d++) chk_dut(d, k, TICK_EN ? (k >= nv[d]) : 1'b1);
        end

        // X128 restart pulse at cnt=70
        for (int i = 0; i < 58; i++) step();
        chk("x128_pre", 2, 32'(phase[2]), 32'd70);
        drst[2] = 1'b1;
        step();
        chk_zero(2, !TICK_EN);
        drst[2] = 1'b0;
        for (int k = 1; k <= 130; k++) begin
            step();
            chk_dut(2, k, TICK_EN ? (k >= 128) : 1'b1);
        end

        // X16: reset and restart together, then restart held past reset release
        rst_n[0] = 1'b0;
        drst[0]  = 1'b1;
        step();
        step();
        chk_zero(0, 1'b0);
        rst_n[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_zero(0, !TICK_EN);
        end
        drst[0] = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            chk_dut(0, k, TICK_EN ? (k >= 16) : 1'b1);
        end

        // X8: reset mid-period, no partial tick, rise 4 edges after release
        chk("x8_mid", 3, 32'(phase[3] != 7'd0), 32'd1);
        rst_n[3] = 1'b0;
        step();
        chk_zero(3, 1'b0);
        rst_n[3] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            chk_dut(3, k, TICK_EN ? (k >= 8) : 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
